// File: rtl/obstacle_spawn_ctrl.sv
// Obstacle spawn sequencer: waits FRAME_PERIOD frame ticks, fetches a random value,
// scales it into [X_MIN, X_MAX] and offers it to the consumer. Optional macro: SPAWN_NODUP_EN.
module obstacle_spawn_ctrl #(
  parameter int unsigned RND_BITS     = 8,
  parameter int unsigned X_BITS       = 11,
  parameter int unsigned X_MIN        = 32,
  parameter int unsigned X_MAX        = 607,
  parameter int unsigned FRAME_PERIOD = 60,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                enable,
  input  logic                startOfFrame,
  input  logic [RND_BITS-1:0] rnd_val,
  input  logic                spawn_ack,
  output logic                rnd_rise,
  output logic                spawn_valid,
  output logic [X_BITS-1:0]   spawn_x,
  output logic [1:0]          spawn_slot,
  output logic                busy
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned RANGE   = X_MAX - X_MIN + 1;
  localparam int unsigned RANGE_W = $clog2(RANGE + 1);
  localparam int unsigned PROD_W  = RND_BITS + RANGE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAMES,
    S_REQ,
    S_WAIT_RND,
    S_CHECK,
    S_MAP,
    S_OFFER
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                wait_cnt_q, wait_cnt_d;
  logic [RND_BITS-1:0] rnd_q, rnd_d;
  logic [X_BITS-1:0]   spawn_x_q, spawn_x_d;
  logic [1:0]          slot_q, slot_d;
  logic                spawn_valid_q, spawn_valid_d;
  logic                rnd_rise_q, rnd_rise_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic                dup_c;
  logic [PROD_W-1:0]   prod_c;
  logic [X_BITS-1:0]   mapped_c;

  // Full-width product so the scaled coordinate can never wrap past X_MAX
  assign prod_c   = PROD_W'(rnd_q) * PROD_W'(RANGE);
  assign mapped_c = X_BITS'(X_MIN) + X_BITS'(prod_c >> RND_BITS);

`ifdef SPAWN_NODUP_EN
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RND_BITS-1:0] last_q;
  logic                last_valid_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                retry_inc_c;

  assign dup_c       = last_valid_q && (rnd_val == last_q) && (retry_q < RETRY_W'(MAX_RETRY));
  assign retry_inc_c = (state_q == S_CHECK) && dup_c;

  // Last accepted value and retry budget for duplicate rejection
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_q       <= '0;
      last_valid_q <= 1'b0;
      retry_q      <= '0;
    end else if (accept_c) begin
      last_q       <= rnd_q;
      last_valid_q <= 1'b1;
      retry_q      <= '0;
    end else if (retry_inc_c) begin
      retry_q      <= retry_q + RETRY_W'(1);
    end
  end
`else
  assign dup_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rnd_d       = rnd_q;
    spawn_x_d   = spawn_x_q;
    slot_d      = slot_q;
    accept_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_WAIT_FRAMES;
          frame_cnt_d = '0;
        end
      end
      S_WAIT_FRAMES: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (startOfFrame) begin
          if (frame_cnt_q == CNT_W'(FRAME_PERIOD - 1)) begin
            state_d     = S_REQ;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      S_REQ: begin
        state_d    = S_WAIT_RND;
        wait_cnt_d = 1'b0;
      end
      S_WAIT_RND: begin
        if (wait_cnt_q) begin
          state_d = S_CHECK;
        end else begin
          wait_cnt_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (dup_c) begin
          state_d = S_REQ;
        end else begin
          rnd_d   = rnd_val;
          state_d = S_MAP;
        end
      end
      S_MAP: begin
        spawn_x_d = mapped_c;
        state_d   = S_OFFER;
      end
      S_OFFER: begin
        // Offer is held until acknowledged; enable only matters after the handshake
        if (spawn_valid_q && spawn_ack) begin
          accept_c    = 1'b1;
          slot_d      = slot_q + 2'd1;
          frame_cnt_d = '0;
          state_d     = enable ? S_WAIT_FRAMES : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rnd_rise_d    = (state_d == S_REQ);
    busy_d        = !((state_d == S_IDLE) || (state_d == S_WAIT_FRAMES));
    spawn_valid_d = (state_q == S_OFFER) && !accept_c;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= '0;
      wait_cnt_q    <= 1'b0;
      rnd_q         <= '0;
      spawn_x_q     <= X_BITS'(X_MIN);
      slot_q        <= 2'd0;
      spawn_valid_q <= 1'b0;
      rnd_rise_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      rnd_q         <= rnd_d;
      spawn_x_q     <= spawn_x_d;
      slot_q        <= slot_d;
      spawn_valid_q <= spawn_valid_d;
      rnd_rise_q    <= rnd_rise_d;
      busy_q        <= busy_d;
    end
  end

  assign rnd_rise    = rnd_rise_q;
  assign spawn_valid = spawn_valid_q;
  assign spawn_x     = spawn_x_q;
  assign spawn_slot  = slot_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_obstacle_spawn_ctrl.sv
// Scoreboard bench for obstacle_spawn_ctrl: directed spawns push expected offers,
// a negedge monitor pops and checks coordinate, slot, latency and request pulse count.
module tb_obstacle_spawn_ctrl;

  localparam int unsigned RB = 8;
  localparam int unsigned XB = 11;
  localparam int unsigned FP = 3;

  logic          clk = 1'b0;
  logic          resetN;
  logic          enable;
  logic          sof;
  logic [RB-1:0] rnd;
  logic          ack;
  logic          rnd_rise;
  logic          spawn_valid;
  logic [XB-1:0] spawn_x;
  logic [1:0]    spawn_slot;
  logic          busy;

  obstacle_spawn_ctrl #(
    .RND_BITS(RB), .X_BITS(XB), .X_MIN(32), .X_MAX(607), .FRAME_PERIOD(FP), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof), .rnd_val(rnd),
    .spawn_ack(ack), .rnd_rise(rnd_rise), .spawn_valid(spawn_valid), .spawn_x(spawn_x),
    .spawn_slot(spawn_slot), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XB-1:0] x;
    logic [1:0]    slot;
    int unsigned   due;
    int unsigned   pulses;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops an expectation on each new offer, checks stability while held
  logic          prev_valid = 1'b0;
  logic          prev_rise  = 1'b0;
  logic [XB-1:0] prev_x     = '0;
  logic [1:0]    prev_slot  = '0;
  int unsigned   pulse_cnt  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetN) begin
      prev_valid = 1'b0;
      prev_rise  = 1'b0;
      pulse_cnt  = 0;
    end else begin
      if (rnd_rise && !prev_rise) pulse_cnt++;
      if (spawn_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_offer", longint'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          check("spawn_x", spawn_x, e.x);
          check("spawn_slot", spawn_slot, e.slot);
          check("valid_rise_edge", cyc, e.due);
          check("rnd_rise_pulses", pulse_cnt, e.pulses);
          check("busy_in_offer", busy, 1);
        end
        pulse_cnt = 0;
      end else if (spawn_valid && prev_valid) begin
        check("x_stable", spawn_x, prev_x);
        check("slot_stable", spawn_slot, prev_slot);
      end
      prev_valid = spawn_valid;
      prev_rise  = rnd_rise;
      prev_x     = spawn_x;
      prev_slot  = spawn_slot;
    end
  end

  // Issue FP frame ticks; expectation is pushed on the final one
  task automatic issue(input logic [RB-1:0] v, input logic [XB-1:0] ex,
                       input logic [1:0] es, input int unsigned retries);
    exp_t        e;
    int unsigned se;
    rnd = v;
    for (int i = 0; i < int'(FP); i++) begin
      @(negedge clk);
      sof = 1'b1;
      se  = cyc + 1;
      if (i == int'(FP) - 1) begin
        e.x      = ex;
        e.slot   = es;
        e.due    = se + 6 + 4 * retries;
        e.pulses = retries + 1;
        sb.push_back(e);
      end
      @(negedge clk);
      sof = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!spawn_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!spawn_valid) check("offer_timeout", 0, 1);
  endtask

  // Hold the offer for 'hold' cycles with frame ticks sprinkled in, then ack
  task automatic ack_after(input int hold);
    for (int i = 0; i < hold; i++) begin
      sof = ((i % 5) == 2);
      @(negedge clk);
    end
    sof = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    resetN = 1'b1;
    enable = 1'b0;
    sof    = 1'b0;
    ack    = 1'b0;
    rnd    = '0;
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rnd_rise", rnd_rise, 0);
    check("rst_valid", spawn_valid, 0);
    check("rst_x", spawn_x, 32);
    check("rst_slot", spawn_slot, 0);
    check("rst_busy", busy, 0);
    resetN = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'd0, 11'd32, 2'd0, 0);
    wait_valid();
    ack_after(0);

    // Early acks while no offer is valid must be ignored
    issue(8'd255, 11'd605, 2'd1, 0);
    ack = 1'b1;
    repeat (4) @(negedge clk);
    ack = 1'b0;
    wait_valid();
    ack_after(0);

    issue(8'd128, 11'd320, 2'd2, 0);
    wait_valid();
    ack_after(0);

    issue(8'd77, 11'd205, 2'd3, 0);
    wait_valid();
    ack_after(0);

`ifdef SPAWN_NODUP_EN
    issue(8'd77, 11'd205, 2'd0, 3);
`else
    issue(8'd77, 11'd205, 2'd0, 0);
`endif
    wait_valid();
    ack_after(50);

    // Enable dropped while waiting for the random value
    issue(8'd10, 11'd54, 2'd1, 0);
    enable = 1'b0;
    wait_valid();
    ack_after(0);
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      @(negedge clk);
    end
    check("idle_no_valid", spawn_valid, 0);
    check("idle_busy_after_ticks", busy, 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'd200, 11'd482, 2'd2, 0);
    wait_valid();
    ack_after(0);

    // Reset while an offer is pending
    issue(8'd1, 11'd34, 2'd3, 0);
    wait_valid();
    #2 resetN = 1'b0;
    #1;
    check("mid_rst_valid", spawn_valid, 0);
    check("mid_rst_x", spawn_x, 32);
    check("mid_rst_slot", spawn_slot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rnd_rise", rnd_rise, 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'd5, 11'd43, 2'd0, 0);
    wait_valid();
    ack_after(0);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_spawn_ctrl.md
OBSTACLE_SPAWN_CTRL -- requirements
Module: obstacle_spawn_ctrl

Interface
REQ-001 Parameter RND_BITS, default 8: width of the random value consumed.
REQ-002 Parameter X_BITS, default 11: width of the spawn coordinate.
REQ-003 Parameter X_MIN, default 32: lowest legal spawn x.
REQ-004 Parameter X_MAX, default 607: highest legal spawn x.
REQ-005 Parameter FRAME_PERIOD, default 60: startOfFrame pulses between spawns, legal range 1..255.
REQ-006 Parameter MAX_RETRY, default 3: maximum re-requests on a duplicate value.
REQ-007 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-008 Port resetN, input, 1: asynchronous active-low reset.
REQ-009 Port enable, input, 1: spawning permitted.
REQ-010 Port startOfFrame, input, 1: one-cycle frame tick.
REQ-011 Port rnd_val, input, RND_BITS: value returned by the random generator.
REQ-012 Port spawn_ack, input, 1: consumer accepts the offered obstacle.
REQ-013 Port rnd_rise, output, 1: request to the generator, which latches a new value on its 0->1 edge.
REQ-014 Port spawn_valid, output, 1: obstacle offer is valid.
REQ-015 Port spawn_x, output, X_BITS: spawn coordinate.
REQ-016 Port spawn_slot, output, 2: round-robin obstacle slot index.
REQ-017 Port busy, output, 1: high in every state except IDLE and WAIT_FRAMES.

Function
REQ-018 The FSM SHALL have these states: IDLE, WAIT_FRAMES, REQ, WAIT_RND, CHECK, MAP, OFFER.
REQ-019 IDLE SHALL go to WAIT_FRAMES when enable=1, clearing the frame counter.
REQ-020 WAIT_FRAMES SHALL count startOfFrame pulses and go to REQ on the clock that samples pulse number FRAME_PERIOD; pulses in all other states are ignored.
REQ-021 REQ SHALL last 1 cycle with rnd_rise=1; rnd_rise SHALL be 0 in all other states, which guarantees a low cycle between requests.
REQ-022 WAIT_RND SHALL last exactly 2 cycles; then CHECK samples rnd_val.
REQ-023 CHECK with SPAWN_NODUP_EN defined: if rnd_val equals the last accepted value, last_valid=1, and retry count < MAX_RETRY, the FSM SHALL increment retry and go to REQ; otherwise it goes to MAP.
REQ-024 MAP SHALL register spawn_x = X_MIN + ((rnd_val * (X_MAX-X_MIN+1)) >> RND_BITS).
  - The product is computed at full width, without truncation.
  - spawn_x never exceeds X_MAX.
REQ-025 OFFER SHALL hold spawn_valid=1 with spawn_x and spawn_slot stable until spawn_ack=1.
  - On that clock it stores the value as last accepted, sets last_valid, increments spawn_slot (mod 4), clears retry, and goes to WAIT_FRAMES with the counter cleared.
REQ-026 spawn_valid SHALL rise exactly 6 cycles after the edge that samples the final startOfFrame when there are no retries; each retry adds 4 cycles.
REQ-027 spawn_ack while spawn_valid=0 SHALL be ignored.
REQ-028 enable=0 in WAIT_FRAMES SHALL return the FSM to IDLE next cycle.
  - In REQ/WAIT_RND/CHECK/MAP the request completes and the FSM proceeds to OFFER.
  - OFFER is never abandoned.
  - After the ack, the FSM goes to IDLE if enable=0.
REQ-029 startOfFrame coinciding with spawn_ack SHALL NOT be counted.

Reset
REQ-030 resetN=0 SHALL asynchronously force:
  - state IDLE, rnd_rise=0, spawn_valid=0, spawn_x=X_MIN, spawn_slot=0, busy=0;
  - frame counter 0, retry 0, last value 0, last_valid=0.
REQ-031 Reset mid-OFFER SHALL drop the offer with no handshake completed and no slot increment.

Configuration
REQ-032 With macro SPAWN_NODUP_EN defined, duplicate rejection per REQ-023 SHALL be compiled in.
REQ-033 Without SPAWN_NODUP_EN, CHECK SHALL always go to MAP, and the retry logic and last-value register SHALL be absent.

Verification
REQ-034 FRAME_PERIOD=3, enable=1, rnd_val=0, ack immediately -> one rnd_rise pulse after the 3rd frame tick; spawn_valid 6 cycles later with spawn_x=32 and slot=0.
REQ-035 rnd_val=255 -> spawn_x=605; rnd_val=128 -> spawn_x=320; slot increments 0,1,2,3,0 over 5 spawns.
REQ-036 NODUP_EN, rnd_val held at 77 for two spawns -> second spawn issues 4 rnd_rise pulses (1+3 retries), then spawn_x=205 and spawn_valid 18 cycles after the tick.
REQ-037 ack held low 50 cycles -> spawn_valid, spawn_x, and slot stay stable; the frame ticks during that time are not counted.
REQ-038 enable dropped in WAIT_RND -> offer still produced, FSM goes to IDLE after the ack; resetN pulsed during OFFER -> all outputs at reset values immediately.
